// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
// Buffer depth and the capture/shift select encoding.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int LEVEL_W   = 2;

  typedef enum logic [2:0] {
    HOLD,
    LOAD0,
    LOAD1,
    SHIFT,
    SHIFT_LOAD1
  } buf_sel_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order output buffer.
// buf0 is always the head; a same-cycle pop frees a slot for the push.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(BUF_DEPTH);
  localparam logic [LEVEL_W-1:0] ONE  = LEVEL_W'(1);

  logic [W-1:0] buf0;
  logic [W-1:0] buf1;
  buf_sel_e     sel;

  always_comb begin
    sel = HOLD;
    unique case (1'b1)
      push && level == '0:          sel = LOAD0;
      push && level == ONE && !pop: sel = LOAD1;
      push && level == ONE && pop:  sel = LOAD0;
      push && level == FULL && pop: sel = SHIFT_LOAD1;
      !push && pop:                 sel = SHIFT;
      default:                      sel = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0  <= '0;
      buf1  <= '0;
      level <= '0;
    end else begin
      level <= level + LEVEL_W'(push) - LEVEL_W'(pop);
      unique case (sel)
        LOAD0: buf0 <= push_data;
        LOAD1: buf1 <= push_data;
        SHIFT: buf0 <= buf1;
        SHIFT_LOAD1: begin
          buf0 <= buf1;
          buf1 <= push_data;
        end
        default: ;
      endcase
    end
  end

  assign head = buf0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: FIFO empty/rd_en to valid/ready stream.
// Reads are issued only when the word can be guaranteed a buffer slot.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DLY        = 1,
  parameter int FIFO_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  fifo_rd_en_o,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  output logic                  m_valid_o,
  output logic [FIFO_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [1:0]            level_o,
  output logic [CNT_W-1:0]      rd_cnt_o
);

  logic               infl;
  logic               pop;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W:0]   occ;
  logic               unused_dly;

  assign unused_dly = ^DLY;

  assign m_valid_o = (level != '0);
  assign pop       = m_valid_o & m_ready_i;

  // occupancy next cycle, counting the word already in flight
  assign occ = {1'b0, level}
             + (LEVEL_W+1)'(infl)
             - (LEVEL_W+1)'(pop);

  assign fifo_rd_en_o = rst_n_i & ~fifo_empty_i
                      & (occ < (LEVEL_W+1)'(BUF_DEPTH));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      infl     <= 1'b0;
      rd_cnt_o <= '0;
    end else begin
      infl <= fifo_rd_en_o;
      if (pop)
        rd_cnt_o <= rd_cnt_o + CNT_W'(1);
    end
  end

  stream_buf2 #(
    .W(FIFO_WIDTH)
  ) u_sbuf (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (infl),
    .push_data (fifo_rd_data_i),
    .pop       (pop),
    .head      (m_data_o),
    .level     (level)
  );

  assign level_o = level;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO model.
// Second instance (CNT_W=4) covers counter wrap.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [1:0]  level;
  logic [15:0] rd_cnt;

  logic        rd_en2;
  logic [7:0]  rd_data2;
  logic        empty2;
  logic        m_valid2;
  logic [7:0]  m_data2;
  logic [1:0]  level2;
  logic [3:0]  rd_cnt2;
  logic        en2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DLY(1), .FIFO_WIDTH(8), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .fifo_rd_en_o   (rd_en),
    .fifo_rd_data_i (rd_data),
    .fifo_empty_i   (empty),
    .m_valid_o      (m_valid),
    .m_data_o       (m_data),
    .m_ready_i      (m_ready),
    .level_o        (level),
    .rd_cnt_o       (rd_cnt)
  );

  fifo_rd_stream #(.DLY(1), .FIFO_WIDTH(8), .CNT_W(4)) dut2 (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .fifo_rd_en_o   (rd_en2),
    .fifo_rd_data_i (rd_data2),
    .fifo_empty_i   (empty2),
    .m_valid_o      (m_valid2),
    .m_data_o       (m_data2),
    .m_ready_i      (1'b1),
    .level_o        (level2),
    .rd_cnt_o       (rd_cnt2)
  );

  // FIFO model: data appears the cycle after rd_en, reset discards
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  int reads2 = 0;
  assign empty2 = !en2 || (reads2 >= 17);

  always @(posedge clk) begin
    if (!rst_n) begin
      reads2   <= 0;
      rd_data2 <= 8'h00;
    end else if (rd_en2) begin
      rd_data2 <= 8'(reads2 + 1);
      reads2   <= reads2 + 1;
    end
  end

  // monitors
  logic [7:0] got [$];
  int rd_pulses = 0;
  int lvl_max   = 0;
  int sum2      = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (rd_en) rd_pulses++;
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (m_valid2) sum2 += int'(m_data2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  int p0;
  int g0;

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    en2     = 1'b0;
    repeat (3) step();
    chk("rst_rden",  32'(rd_en),   0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data",  32'(m_data),  0);
    chk("rst_level", 32'(level),   0);
    chk("rst_cnt",   32'(rd_cnt),  0);

    // idle with FIFO empty
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rden",  32'(rd_en),   0);
      chk("idle_valid", 32'(m_valid), 0);
    end
    chk("idle_level", 32'(level),  0);
    chk("idle_cnt",   32'(rd_cnt), 0);

    // full-throughput stream
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    #1;
    chk("lat_rden_t0",  32'(rd_en),   1);
    chk("lat_valid_t0", 32'(m_valid), 0);
    step();
    chk("lat_rden_t1",  32'(rd_en),   1);
    chk("lat_valid_t1", 32'(m_valid), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("tp_valid", 32'(m_valid), 1);
      chk("tp_data",  32'(m_data),  32'(i + 1));
    end
    step();
    chk("tp_valid_end", 32'(m_valid), 0);
    chk("tp_cnt",       32'(rd_cnt),  8);

    // backpressure then drain
    m_ready = 1'b0;
    p0 = rd_pulses;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    repeat (10) step();
    chk("bp_hold_mid", 32'(m_data), 1);
    repeat (10) step();
    chk("bp_reads", 32'(rd_pulses - p0), 2);
    chk("bp_level", 32'(level),   2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_data",  32'(m_data),  1);
    chk("bp_rden",  32'(rd_en),   0);
    m_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("drain_valid", 32'(m_valid), 1);
      chk("drain_data",  32'(m_data),  32'(i + 1));
    end
    step();
    chk("drain_end", 32'(m_valid), 0);
    chk("drain_cnt", 32'(rd_cnt),  16);

    // toggling ready
    g0 = got.size();
    lvl_max = 0;
    for (int i = 0; i < 16; i++) wr(8'(8'hA0 + i));
    for (int c = 0; c < 60; c++) begin
      m_ready = (c % 2 == 0);
      step();
    end
    m_ready = 1'b1;
    repeat (5) step();
    chk("tog_count", 32'(got.size() - g0), 16);
    for (int i = 0; i < 16; i++) begin
      if (g0 + i < got.size())
        chk("tog_order", 32'(got[g0 + i]), 32'(8'hA0 + i));
    end
    chk("tog_lvl_max", 32'(lvl_max <= 2), 1);
    chk("tog_cnt",     32'(rd_cnt), 32);

    // reset with a buffered and an in-flight word
    m_ready = 1'b0;
    wr(8'hC1);
    wr(8'hC2);
    wr(8'hC3);
    step();
    step();
    chk("mid_level", 32'(level), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rden_gated", 32'(rd_en), 0);
    step();
    chk("mid_valid", 32'(m_valid), 0);
    chk("mid_level0", 32'(level), 0);
    chk("mid_cnt",   32'(rd_cnt),  0);
    chk("mid_data",  32'(m_data),  0);
    rst_n = 1'b1;
    #1;
    chk("mid_rden", 32'(rd_en), 0);
    step();
    chk("mid_valid_after", 32'(m_valid), 0);

    // counter wrap on the CNT_W=4 instance
    en2 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (reads2 == 17 && !m_valid2 && level2 == 2'd0) break;
    end
    chk("wrap_reads", 32'(reads2),  17);
    chk("wrap_level", 32'(level2),  0);
    chk("wrap_cnt",   32'(rd_cnt2), 1);
    chk("wrap_sum",   32'(sum2),    153);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
